// File: rtl/mm_tile_ctrl.sv
// mm_tile_ctrl: matrix-multiply sequencer for the MAC array.
// Walks the output matrix tile by tile and drives A/B buffer read addresses plus
// accumulator write/clear control. INT8/INT4 run a MAX pass followed by a CALC
// pass; INT4_VSQ runs a single CALC pass.
// Optional feature: define MM_PPU_BP_EN to enable PPU back-pressure, which holds
// o_ppu_valid until accepted and parks the FSM in WAIT_PPU between tiles.

module mm_tile_ctrl #(
  parameter int AD     = 8,
  parameter int DIM_W  = 8,
  parameter int ADDR_W = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [1:0]            i_mode,
  input  logic [DIM_W-1:0]      i_m_tiles,
  input  logic [DIM_W-1:0]      i_n_tiles,
  input  logic [DIM_W-1:0]      i_k_steps,
  input  logic                  i_stall,
  input  logic                  i_abort,
  input  logic                  i_ppu_ready,
  output logic [ADDR_W-1:0]     o_a_addr,
  output logic [ADDR_W-1:0]     o_b_addr,
  output logic                  o_acc_we,
  output logic                  o_acc_clr,
  output logic [$clog2(AD)-1:0] o_acc_addr,
  output logic                  o_max_pass,
  output logic                  o_ppu_valid,
  output logic                  o_tile_done,
  output logic                  o_mtrx_done,
  output logic                  o_err,
  output logic                  o_busy,
  output logic [1:0]            o_mode
);

  localparam int               ACC_W   = $clog2(AD);
  localparam logic [ACC_W-1:0] B_LAST  = ACC_W'(AD - 1);
  localparam logic [ACC_W-1:0] B_ONE   = ACC_W'(1);
  localparam logic [DIM_W-1:0] DIM_ONE = DIM_W'(1);
  localparam logic [1:0]       MODE_VSQ = 2'd2;
  localparam logic [1:0]       MODE_RSV = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MAX      = 2'd1,
    ST_CALC     = 2'd2,
    ST_WAIT_PPU = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [1:0]       mode_q, mode_d;
  logic [DIM_W-1:0] m_q, m_d;
  logic [DIM_W-1:0] n_q, n_d;
  logic [DIM_W-1:0] k_q, k_d;

  logic [ACC_W-1:0] b_cnt, b_d, b_nx;
  logic [DIM_W-1:0] a_cnt, a_d, a_nx;
  logic [DIM_W-1:0] col_cnt, col_d, col_nx;
  logic [DIM_W-1:0] row_cnt, row_d, row_nx;

  logic b_last, a_last, col_last, row_last;
  logic tile_end, last_tile;
  logic start_ok, beat, abort_act, ppu_block;

  logic tile_done_q, tile_done_d;
  logic mtrx_done_q, mtrx_done_d;
  logic err_q, err_d;
  logic ppu_valid_q, ppu_valid_d;

  logic [ADDR_W-1:0] n_span;

  // A start is only meaningful with a non-empty matrix and a defined mode
  assign start_ok = (i_m_tiles != '0) && (i_n_tiles != '0) &&
                    (i_k_steps != '0) && (i_mode != MODE_RSV);

  // Wrap detection and the counter values one beat ahead, b fastest
  always_comb begin
    b_last    = (b_cnt == B_LAST);
    a_last    = (a_cnt == k_q - DIM_ONE);
    col_last  = (col_cnt == n_q - DIM_ONE);
    row_last  = (row_cnt == m_q - DIM_ONE);
    tile_end  = b_last && a_last;
    last_tile = col_last && row_last;

    b_nx   = b_last ? '0 : b_cnt + B_ONE;
    a_nx   = a_cnt;
    col_nx = col_cnt;
    row_nx = row_cnt;
    if (b_last) begin
      a_nx = a_last ? '0 : a_cnt + DIM_ONE;
    end
    if (tile_end) begin
      col_nx = col_last ? '0 : col_cnt + DIM_ONE;
    end
    if (tile_end && col_last) begin
      row_nx = row_last ? '0 : row_cnt + DIM_ONE;
    end
  end

`ifdef MM_PPU_BP_EN
  // A new CALC tile may not start while the previous one is still unaccepted
  always_comb begin
    ppu_block = ppu_valid_q && !i_ppu_ready && (b_cnt == '0) && (a_cnt == '0);
  end
`else
  logic unused_ppu_ready;
  assign unused_ppu_ready = i_ppu_ready;
  assign ppu_block        = 1'b0;
`endif

  // Next state, counter advance and completion pulses
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    m_d         = m_q;
    n_d         = n_q;
    k_d         = k_q;
    b_d         = b_cnt;
    a_d         = a_cnt;
    col_d       = col_cnt;
    row_d       = row_cnt;
    beat        = 1'b0;
    abort_act   = 1'b0;
    tile_done_d = 1'b0;
    mtrx_done_d = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          if (start_ok) begin
            mode_d  = i_mode;
            m_d     = i_m_tiles;
            n_d     = i_n_tiles;
            k_d     = i_k_steps;
            b_d     = '0;
            a_d     = '0;
            col_d   = '0;
            row_d   = '0;
            state_d = (i_mode == MODE_VSQ) ? ST_CALC : ST_MAX;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_MAX, ST_CALC: begin
        if (i_abort) begin
          abort_act = 1'b1;
        end else if (!i_stall) begin
          if ((state_q == ST_CALC) && ppu_block) begin
            state_d = ST_WAIT_PPU;
          end else begin
            beat  = 1'b1;
            b_d   = b_nx;
            a_d   = a_nx;
            col_d = col_nx;
            row_d = row_nx;
            if (state_q == ST_CALC && tile_end) begin
              tile_done_d = 1'b1;
            end
            if (tile_end && last_tile) begin
              if (state_q == ST_MAX) begin
                state_d = ST_CALC;
              end else begin
                mtrx_done_d = 1'b1;
                state_d     = ST_IDLE;
              end
            end
          end
        end
      end
      ST_WAIT_PPU: begin
        if (i_abort) begin
          abort_act = 1'b1;
        end else if (!i_stall && (!ppu_valid_q || i_ppu_ready)) begin
          state_d = ST_CALC;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (abort_act) begin
      state_d = ST_IDLE;
      b_d     = '0;
      a_d     = '0;
      col_d   = '0;
      row_d   = '0;
    end
  end

  // PPU valid: held until accepted with back-pressure, else mirrors tile_done
  always_comb begin
`ifdef MM_PPU_BP_EN
    ppu_valid_d = ppu_valid_q;
    if (abort_act) begin
      ppu_valid_d = 1'b0;
    end else if (tile_done_d) begin
      ppu_valid_d = 1'b1;
    end else if (i_ppu_ready) begin
      ppu_valid_d = 1'b0;
    end
`else
    ppu_valid_d = tile_done_d;
`endif
  end

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Latched configuration, sweep counters and registered status pulses
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mode_q      <= '0;
      m_q         <= '0;
      n_q         <= '0;
      k_q         <= '0;
      b_cnt       <= '0;
      a_cnt       <= '0;
      col_cnt     <= '0;
      row_cnt     <= '0;
      tile_done_q <= 1'b0;
      mtrx_done_q <= 1'b0;
      err_q       <= 1'b0;
      ppu_valid_q <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      m_q         <= m_d;
      n_q         <= n_d;
      k_q         <= k_d;
      b_cnt       <= b_d;
      a_cnt       <= a_d;
      col_cnt     <= col_d;
      row_cnt     <= row_d;
      tile_done_q <= tile_done_d;
      mtrx_done_q <= mtrx_done_d;
      err_q       <= err_d;
      ppu_valid_q <= ppu_valid_d;
    end
  end

  // Buffer addresses straight from the counters, wrapping modulo 2^ADDR_W
  always_comb begin
    n_span   = ADDR_W'(n_q) * ADDR_W'(AD);
    o_a_addr = ADDR_W'(a_cnt) + ADDR_W'(row_cnt) * ADDR_W'(k_q);
    o_b_addr = ADDR_W'(b_cnt) + ADDR_W'(a_cnt) * n_span +
               ADDR_W'(col_cnt) * ADDR_W'(AD);
  end

  assign o_acc_we    = beat;
  assign o_acc_clr   = ((state_q == ST_MAX) || (state_q == ST_CALC)) && (a_cnt == '0);
  assign o_acc_addr  = b_cnt;
  assign o_max_pass  = (state_q == ST_MAX);
  assign o_ppu_valid = ppu_valid_q;
  assign o_tile_done = tile_done_q;
  assign o_mtrx_done = mtrx_done_q;
  assign o_err       = err_q;
  assign o_busy      = (state_q != ST_IDLE);
  assign o_mode      = mode_q;

endmodule

// File: tb/tb_mm_tile_ctrl.sv
// tb_mm_tile_ctrl: randomized self-checking bench for mm_tile_ctrl.
// The reference model expands each accepted matrix into its ordered list of
// beats from the address formulas, then walks that list cycle by cycle.

module tb_mm_tile_ctrl;

  localparam int AD     = 8;
  localparam int DIM_W  = 8;
  localparam int ADDR_W = 16;

  logic              i_clk = 1'b0;
  logic              i_rst_n = 1'b0;
  logic              i_start = 1'b0;
  logic [1:0]        i_mode = '0;
  logic [DIM_W-1:0]  i_m_tiles = '0;
  logic [DIM_W-1:0]  i_n_tiles = '0;
  logic [DIM_W-1:0]  i_k_steps = '0;
  logic              i_stall = 1'b0;
  logic              i_abort = 1'b0;
  logic              i_ppu_ready = 1'b0;
  logic [ADDR_W-1:0] o_a_addr;
  logic [ADDR_W-1:0] o_b_addr;
  logic              o_acc_we;
  logic              o_acc_clr;
  logic [2:0]        o_acc_addr;
  logic              o_max_pass;
  logic              o_ppu_valid;
  logic              o_tile_done;
  logic              o_mtrx_done;
  logic              o_err;
  logic              o_busy;
  logic [1:0]        o_mode;

  mm_tile_ctrl #(.AD(AD), .DIM_W(DIM_W), .ADDR_W(ADDR_W)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_mode(i_mode),
    .i_m_tiles(i_m_tiles), .i_n_tiles(i_n_tiles), .i_k_steps(i_k_steps),
    .i_stall(i_stall), .i_abort(i_abort), .i_ppu_ready(i_ppu_ready),
    .o_a_addr(o_a_addr), .o_b_addr(o_b_addr), .o_acc_we(o_acc_we),
    .o_acc_clr(o_acc_clr), .o_acc_addr(o_acc_addr), .o_max_pass(o_max_pass),
    .o_ppu_valid(o_ppu_valid), .o_tile_done(o_tile_done),
    .o_mtrx_done(o_mtrx_done), .o_err(o_err), .o_busy(o_busy), .o_mode(o_mode)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int a_addr;
    int b_addr;
    int acc;
    bit clr;
    bit mx;
    bit tend;
    bit mend;
    bit tstart;
  } beat_t;

  beat_t beats[$];
  int    idx;
  bit    active, waiting;
  bit    exp_td, exp_md, exp_err, exp_pv;
  int    exp_mode;
  int    n_vec, n_bad;
  int    cyc_no;
  int    td_cycle;
  int    obs_beats, obs_td, obs_md, obs_clr, obs_max;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic clearObs();
    obs_beats = 0; obs_td = 0; obs_md = 0; obs_clr = 0; obs_max = 0;
    td_cycle  = -1;
  endtask

  // Ordered beat list of one matrix, straight from the address formulas
  task automatic buildBeats(input int mode, input int m, input int n, input int k);
    beat_t bt;
    beats.delete();
    for (int p = (mode == 2) ? 1 : 0; p < 2; p++)
      for (int row = 0; row < m; row++)
        for (int col = 0; col < n; col++)
          for (int a = 0; a < k; a++)
            for (int b = 0; b < AD; b++) begin
              bt.a_addr = (a + row * k) % 65536;
              bt.b_addr = (b + a * n * AD + col * AD) % 65536;
              bt.acc    = b;
              bt.clr    = (a == 0);
              bt.mx     = (p == 0);
              bt.tend   = (p == 1) && (a == k - 1) && (b == AD - 1);
              bt.mend   = bt.tend && (row == m - 1) && (col == n - 1);
              bt.tstart = (a == 0) && (b == 0);
              beats.push_back(bt);
            end
  endtask

  // One clock: drive inputs, compare against the model, advance the model
  task automatic applyStimulus(input bit start, input int mode, input int m, input int n,
                               input int k, input bit stall, input bit abort, input bit ready);
    bit    nx_td, nx_md, nx_err, cur_we, show, was_active;
    beat_t cur;
    nx_td = 0; nx_md = 0; nx_err = 0; cur_we = 0;
    @(negedge i_clk);
    i_start     = start;
    i_mode      = 2'(mode);
    i_m_tiles   = DIM_W'(m);
    i_n_tiles   = DIM_W'(n);
    i_k_steps   = DIM_W'(k);
    i_stall     = stall;
    i_abort     = abort;
    i_ppu_ready = ready;
    #1;
    cyc_no++;
    checkOutput("tile_done", 32'(o_tile_done), 32'(exp_td));
    checkOutput("mtrx_done", 32'(o_mtrx_done), 32'(exp_md));
    checkOutput("err", 32'(o_err), 32'(exp_err));
    checkOutput("ppu_valid", 32'(o_ppu_valid), 32'(exp_pv));
    checkOutput("mode", 32'(o_mode), 32'(exp_mode));
    checkOutput("busy", 32'(o_busy), 32'(active));
    cur = '{default: 0};
    if (active) cur = beats[idx];
    show = active && !waiting;
    checkOutput("a_addr", 32'(o_a_addr), 32'(cur.a_addr));
    checkOutput("b_addr", 32'(o_b_addr), 32'(cur.b_addr));
    checkOutput("acc_addr", 32'(o_acc_addr), 32'(cur.acc));
    checkOutput("max_pass", 32'(o_max_pass), 32'(show && cur.mx));
    checkOutput("acc_clr", 32'(o_acc_clr), 32'(show && cur.clr));
    if (o_tile_done) begin
      obs_td++;
      if (td_cycle < 0) td_cycle = cyc_no;
    end
    if (o_mtrx_done) obs_md++;
    was_active = active;
    if (!active) begin
      if (start) begin
        if (m != 0 && n != 0 && k != 0 && mode != 3) begin
          buildBeats(mode, m, n, k);
          idx = 0; active = 1; waiting = 0; exp_mode = mode;
        end else begin
          nx_err = 1;
        end
      end
    end else if (abort) begin
      active = 0; waiting = 0;
    end else if (waiting) begin
      if (!stall && (!exp_pv || ready)) waiting = 0;
    end else if (stall) begin
      cur_we = 0;
`ifdef MM_PPU_BP_EN
    end else if (!cur.mx && cur.tstart && exp_pv && !ready) begin
      waiting = 1;
`endif
    end else begin
      cur_we = 1;
      nx_td  = cur.tend;
      nx_md  = cur.mend;
      idx++;
      if (idx == beats.size()) active = 0;
    end
    checkOutput("acc_we", 32'(o_acc_we), 32'(cur_we));
    if (o_acc_we) begin
      obs_beats++;
      if (o_acc_clr) obs_clr++;
      if (o_max_pass) obs_max++;
    end
`ifdef MM_PPU_BP_EN
    if (abort && was_active) exp_pv = 0;
    else if (nx_td) exp_pv = 1;
    else if (ready) exp_pv = 0;
`else
    exp_pv = nx_td;
`endif
    exp_td  = nx_td;
    exp_md  = nx_md;
    exp_err = nx_err;
  endtask

  // Start one matrix and sequence it with random stalls, starts and ready
  task automatic runMatrix(input int mode, input int m, input int n, input int k,
                           input int stall_pct, input int abort_at, input int ready_pct,
                           input int final_stall, input int max_cyc);
    int  cyc;
    int  fs_left;
    bit  st, ab;
    fs_left = final_stall;
    cyc     = 0;
    applyStimulus(1, mode, m, n, k, 0, 0, $urandom_range(99) < 32'(ready_pct));
    while (active && cyc < max_cyc) begin
      st = ($urandom_range(99) < 32'(stall_pct));
      if (fs_left > 0 && idx == AD * k - 1) begin
        st = 1;
        fs_left--;
      end
      ab = (cyc == abort_at);
      applyStimulus($urandom_range(9) == 0, $urandom_range(3), m, n, k, st, ab,
                    $urandom_range(99) < 32'(ready_pct));
      cyc++;
    end
    if (max_cyc >= 5000 && active) begin
      checkOutput("timeout", 32'(0), 32'(1));
    end
  endtask

  task automatic idleCycles(input int count, input int ready_pct);
    for (int i = 0; i < count; i++)
      applyStimulus(0, 0, 1, 1, 1, 0, 0, $urandom_range(99) < 32'(ready_pct));
  endtask

  // Asynchronous reset in the middle of a cycle; every output must clear at once
  task automatic doReset();
    @(negedge i_clk);
    #2;
    i_rst_n = 1'b0;
    #1;
    checkOutput("rst_busy", 32'(o_busy), 32'(0));
    checkOutput("rst_acc_we", 32'(o_acc_we), 32'(0));
    checkOutput("rst_acc_clr", 32'(o_acc_clr), 32'(0));
    checkOutput("rst_a_addr", 32'(o_a_addr), 32'(0));
    checkOutput("rst_b_addr", 32'(o_b_addr), 32'(0));
    checkOutput("rst_acc_addr", 32'(o_acc_addr), 32'(0));
    checkOutput("rst_max_pass", 32'(o_max_pass), 32'(0));
    checkOutput("rst_ppu_valid", 32'(o_ppu_valid), 32'(0));
    checkOutput("rst_tile_done", 32'(o_tile_done), 32'(0));
    checkOutput("rst_mtrx_done", 32'(o_mtrx_done), 32'(0));
    checkOutput("rst_err", 32'(o_err), 32'(0));
    checkOutput("rst_mode", 32'(o_mode), 32'(0));
    active = 0; waiting = 0; idx = 0;
    exp_td = 0; exp_md = 0; exp_err = 0; exp_pv = 0; exp_mode = 0;
    @(negedge i_clk);
    i_start = 1'b0;
    i_abort = 1'b0;
    i_stall = 1'b0;
    i_rst_n = 1'b1;
  endtask

  initial begin
    int start_cyc;
    n_vec = 0; n_bad = 0; cyc_no = 0;
    clearObs();
    doReset();
    idleCycles(3, 50);

    $display("[TB] INT4_VSQ m=2 n=2 k=3");
    clearObs();
    runMatrix(2, 2, 2, 3, 0, -1, 100, 0, 5000);
    idleCycles(3, 100);
    checkOutput("vsq_beats", 32'(obs_beats), 32'(96));
    checkOutput("vsq_tiles", 32'(obs_td), 32'(4));
    checkOutput("vsq_mtrx", 32'(obs_md), 32'(1));
    checkOutput("vsq_clr", 32'(obs_clr), 32'(32));

    $display("[TB] INT8 m=1 n=2 k=2");
    clearObs();
    runMatrix(0, 1, 2, 2, 0, -1, 100, 0, 5000);
    idleCycles(3, 100);
    checkOutput("int8_max", 32'(obs_max), 32'(32));
    checkOutput("int8_beats", 32'(obs_beats), 32'(64));
    checkOutput("int8_tiles", 32'(obs_td), 32'(2));

    $display("[TB] five-cycle stall on the final beat of a tile");
    clearObs();
    start_cyc = cyc_no + 1;
    runMatrix(2, 1, 1, 2, 0, -1, 100, 5, 5000);
    idleCycles(3, 100);
    checkOutput("stall_td_delay", 32'(td_cycle - start_cyc), 32'(AD * 2 + 1 + 5));

    $display("[TB] rejected starts");
    clearObs();
    runMatrix(0, 1, 1, 0, 0, -1, 100, 0, 5000);
    idleCycles(2, 100);
    runMatrix(3, 1, 1, 1, 0, -1, 100, 0, 5000);
    idleCycles(2, 100);

    $display("[TB] abort during MAX then restart");
    clearObs();
    runMatrix(1, 1, 1, 2, 0, 5, 100, 0, 5000);
    idleCycles(2, 100);
    checkOutput("abort_no_td", 32'(obs_td), 32'(0));
    checkOutput("abort_no_md", 32'(obs_md), 32'(0));
    runMatrix(1, 1, 1, 2, 20, -1, 100, 0, 5000);
    idleCycles(3, 100);

`ifdef MM_PPU_BP_EN
    $display("[TB] PPU back-pressure with slow ready");
    runMatrix(2, 1, 3, 1, 0, -1, 8, 0, 5000);
    idleCycles(30, 8);
`endif

    $display("[TB] random matrices");
    for (int t = 0; t < 12; t++) begin
      int md, mm, nn, kk, ab;
      md = $urandom_range(3);
      mm = $urandom_range(1, 3);
      nn = $urandom_range(1, 3);
      kk = ($urandom_range(7) == 0) ? 0 : $urandom_range(1, 3);
      ab = ($urandom_range(4) == 0) ? $urandom_range(60) : -1;
      runMatrix(md, mm, nn, kk, 25, ab, 60, 0, 5000);
      idleCycles($urandom_range(1, 4), 60);
    end

    $display("[TB] reset mid-CALC");
    runMatrix(2, 2, 2, 3, 10, -1, 100, 0, 30);
    doReset();
    idleCycles(3, 100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

endmodule
